alu_sequencer: RTL and testbench

Multi-cycle execute stage that sits directly upstream of the 4-bit ALU. It accepts one decoded ALU instruction per start/done handshake. It fetches the destination and source nibbles from the register file (A/B), from nibble RAM addressed by X/Y, or from an immediate, and presents them to the ALU as temp_a/temp_b. It then owns the carry/zero flag registers and writes the result back to register or RAM.

---
 rtl/alu_sequencer_if.sv | 69 ++++++
 rtl/alu_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Shared ALU operation type plus the instruction/register/RAM bundle that
// connects the CPU side to the multi-cycle ALU sequencer.

package alu_types_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOT = 4'd5,
        ALU_RRC = 4'd6,
        ALU_RLC = 4'd7,
        ALU_CP  = 4'd8
    } alu_op;
endpackage

interface alu_sequencer_if #(
    parameter int ADDR_WIDTH = 12
);
    import alu_types_pkg::*;

    // instruction handshake
    logic                  start;
    alu_op                 op;
    logic                  op_use_carry;
    logic [1:0]            dst_sel;
    logic [2:0]            src_sel;
    logic [3:0]            imm;
    logic                  flag_decimal;
    logic                  busy;
    logic                  done;

    // register file
    logic [3:0]            reg_a;
    logic [3:0]            reg_b;
    logic [ADDR_WIDTH-1:0] reg_x;
    logic [ADDR_WIDTH-1:0] reg_y;
    logic                  reg_we_a;
    logic                  reg_we_b;
    logic [3:0]            reg_wdata;

    // nibble RAM
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [3:0]            mem_wdata;
    logic [3:0]            mem_rdata;

    // status flags owned by the sequencer
    logic                  flag_carry;
    logic                  flag_zero;

    // CPU / environment side
    modport master (
        output start, op, op_use_carry, dst_sel, src_sel, imm, flag_decimal,
        output reg_a, reg_b, reg_x, reg_y, mem_rdata,
        input  busy, done, reg_we_a, reg_we_b, reg_wdata,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, flag_carry, flag_zero
    );

    // sequencer side
    modport slave (
        input  start, op, op_use_carry, dst_sel, src_sel, imm, flag_decimal,
        input  reg_a, reg_b, reg_x, reg_y, mem_rdata,
        output busy, done, reg_we_a, reg_we_b, reg_wdata,
        output mem_addr, mem_rd, mem_wr, mem_wdata, flag_carry, flag_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle execute stage in front of the 4-bit ALU: fetches the two
// operands (register, RAM via X/Y, or immediate), runs the ALU, owns the
// carry/zero flags and writes the result back to register or RAM.

module alu_sequencer
    import alu_types_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_WAIT_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_WAIT_B = 3'd4,
        S_EXEC   = 3'd5,
        S_WRITE  = 3'd6
    } state_t;

    state_t     state_q, state_d;
    alu_op      op_q, op_d;
    logic       use_carry_q, use_carry_d;
    logic [1:0] dst_q, dst_d;
    logic [2:0] src_q, src_d;
    logic [3:0] imm_q, imm_d;
    logic [3:0] temp_a_q, temp_a_d;
    logic [3:0] temp_b_q, temp_b_d;
    logic [3:0] result_q, result_d;
    logic       flag_carry_q, flag_carry_d;
    logic       flag_zero_q, flag_zero_d;

    // combinational ALU
    logic [3:0] alu_out;
    logic       alu_carry;
    logic       alu_zero;
    logic       alu_cin;
    logic [4:0] alu_wide;

    // decoded helpers
    logic                  is_unary;
    logic                  dst_is_mem;
    logic                  src_is_mem;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [ADDR_WIDTH-1:0] src_addr;

    // output drivers
    logic                  busy_o;
    logic                  done_o;
    logic                  we_a_o;
    logic                  we_b_o;
    logic [3:0]            reg_wdata_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_rd_o;
    logic                  mem_wr_o;
    logic [3:0]            mem_wdata_o;

    // X/Y are read live, never latched: the CPU holds them stable while busy
    assign is_unary   = (op_q == ALU_NOT) || (op_q == ALU_RRC) || (op_q == ALU_RLC);
    assign dst_is_mem = dst_q[1];
    assign src_is_mem = (src_q == 3'd2) || (src_q == 3'd3);
    assign dst_addr   = dst_q[0] ? bus.reg_y : bus.reg_x;
    assign src_addr   = src_q[0] ? bus.reg_y : bus.reg_x;

    // 4-bit ALU; SUB/CP carry is a borrow, logic ops pass the old carry through
    always_comb begin
        alu_out   = 4'h0;
        alu_carry = flag_carry_q;
        alu_wide  = 5'h00;
        alu_cin   = use_carry_q & flag_carry_q;
        case (op_q)
            ALU_ADD: begin
                alu_wide = {1'b0, temp_a_q} + {1'b0, temp_b_q} + {4'h0, alu_cin};
                if (bus.flag_decimal && (alu_wide > 5'd9)) begin
                    alu_out   = alu_wide[3:0] + 4'd6;
                    alu_carry = 1'b1;
                end else begin
                    alu_out   = alu_wide[3:0];
                    alu_carry = alu_wide[4];
                end
            end
            ALU_SUB: begin
                alu_wide  = {1'b0, temp_a_q} - {1'b0, temp_b_q} - {4'h0, alu_cin};
                alu_carry = alu_wide[4];
                alu_out   = (alu_wide[4] && bus.flag_decimal) ? (alu_wide[3:0] - 4'd6)
                                                              : alu_wide[3:0];
            end
            ALU_CP: begin
                alu_wide  = {1'b0, temp_a_q} - {1'b0, temp_b_q};
                alu_carry = alu_wide[4];
                alu_out   = alu_wide[3:0];
            end
            ALU_AND: alu_out = temp_a_q & temp_b_q;
            ALU_OR:  alu_out = temp_a_q | temp_b_q;
            ALU_XOR: alu_out = temp_a_q ^ temp_b_q;
            ALU_NOT: alu_out = ~temp_a_q;
            ALU_RRC: begin
                alu_out   = {flag_carry_q, temp_a_q[3:1]};
                alu_carry = temp_a_q[0];
            end
            ALU_RLC: begin
                alu_out   = {temp_a_q[2:0], flag_carry_q};
                alu_carry = temp_a_q[3];
            end
            default: ;
        endcase
    end

    assign alu_zero = (alu_out == 4'h0);

    // sequencer next-state, operand capture and write-back strobes
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        use_carry_d  = use_carry_q;
        dst_d        = dst_q;
        src_d        = src_q;
        imm_d        = imm_q;
        temp_a_d     = temp_a_q;
        temp_b_d     = temp_b_q;
        result_d     = result_q;
        flag_carry_d = flag_carry_q;
        flag_zero_d  = flag_zero_q;
        done_o       = 1'b0;
        we_a_o       = 1'b0;
        we_b_o       = 1'b0;
        reg_wdata_o  = 4'h0;
        mem_addr_o   = '0;
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        mem_wdata_o  = 4'h0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d        = bus.op;
                    use_carry_d = bus.op_use_carry;
                    dst_d       = bus.dst_sel;
                    src_d       = bus.src_sel;
                    imm_d       = bus.imm;
                    state_d     = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (dst_is_mem) begin
                    mem_addr_o = dst_addr;
                    mem_rd_o   = 1'b1;
                    state_d    = S_WAIT_A;
                end else begin
                    temp_a_d = dst_q[0] ? bus.reg_b : bus.reg_a;
                    // unary ops bypass the second fetch so they retire a cycle early
                    if (is_unary) begin
                        temp_b_d = 4'h0;
                        state_d  = S_EXEC;
                    end else begin
                        state_d  = S_LOAD_B;
                    end
                end
            end
            S_WAIT_A: begin
                temp_a_d = bus.mem_rdata;
                if (is_unary) begin
                    temp_b_d = 4'h0;
                    state_d  = S_EXEC;
                end else begin
                    state_d  = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (is_unary) begin
                    temp_b_d = 4'h0;
                    state_d  = S_EXEC;
                end else if (src_is_mem) begin
                    mem_addr_o = src_addr;
                    mem_rd_o   = 1'b1;
                    state_d    = S_WAIT_B;
                end else begin
                    case (src_q)
                        3'd0:    temp_b_d = bus.reg_a;
                        3'd1:    temp_b_d = bus.reg_b;
                        default: temp_b_d = imm_q;
                    endcase
                    state_d = S_EXEC;
                end
            end
            S_WAIT_B: begin
                temp_b_d = bus.mem_rdata;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                result_d     = alu_out;
                flag_carry_d = alu_carry;
                flag_zero_d  = alu_zero;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                done_o = 1'b1;
                if (op_q != ALU_CP) begin
                    case (dst_q)
                        2'd0: begin
                            we_a_o      = 1'b1;
                            reg_wdata_o = result_q;
                        end
                        2'd1: begin
                            we_b_o      = 1'b1;
                            reg_wdata_o = result_q;
                        end
                        default: begin
                            mem_wr_o    = 1'b1;
                            mem_addr_o  = dst_addr;
                            mem_wdata_o = result_q;
                        end
                    endcase
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            op_q         <= ALU_ADD;
            use_carry_q  <= 1'b0;
            dst_q        <= 2'd0;
            src_q        <= 3'd0;
            imm_q        <= 4'h0;
            temp_a_q     <= 4'h0;
            temp_b_q     <= 4'h0;
            result_q     <= 4'h0;
            flag_carry_q <= 1'b0;
            flag_zero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            use_carry_q  <= use_carry_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            imm_q        <= imm_d;
            temp_a_q     <= temp_a_d;
            temp_b_q     <= temp_b_d;
            result_q     <= result_d;
            flag_carry_q <= flag_carry_d;
            flag_zero_q  <= flag_zero_d;
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign bus.busy       = busy_o;
    assign bus.done       = done_o;
    assign bus.reg_we_a   = we_a_o;
    assign bus.reg_we_b   = we_b_o;
    assign bus.reg_wdata  = reg_wdata_o;
    assign bus.mem_addr   = mem_addr_o;
    assign bus.mem_rd     = mem_rd_o;
    assign bus.mem_wr     = mem_wr_o;
    assign bus.mem_wdata  = mem_wdata_o;
    assign bus.flag_carry = flag_carry_q;
    assign bus.flag_zero  = flag_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases, a randomized
// back-to-back run against an arithmetic reference model, busy/start
// robustness and a mid-instruction reset.
`timescale 1ns/1ps
module tb_alu_sequencer;
    import alu_types_pkg::*;

    localparam int AW = 12;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_sequencer_if #(.ADDR_WIDTH(AW)) bus();
    alu_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int passed = 0;

    // nibble RAM with one-cycle read latency; pre_* loads it between instructions
    logic [3:0]    ram [0:4095];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [3:0]    pre_data;
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
    end

    // flags as the architecture should hold them
    int model_c = 0;

    // observations gathered by run_instr
    int            obs_lat, obs_rd_cnt, obs_wr_cnt, obs_wr_kind, obs_conflict, obs_busy_gap;
    bit            obs_timeout;
    logic          obs_busy_after, obs_done_after;
    logic [AW-1:0] obs_rd_addr [4];
    logic [AW-1:0] obs_wr_addr;
    logic [3:0]    obs_wr_data;

    // reference ALU from the arithmetic rules (carry of SUB/CP is borrow)
    function automatic void ref_alu(input alu_op op, input int a, input int b, input int cin,
                                    input bit uc, input bit dec, output int r, output int c);
        int s;
        r = 0;
        c = cin;
        case (op)
            ALU_ADD: begin
                s = a + b + (uc ? cin : 0);
                if (dec && s > 9) begin r = (s - 10) % 16; c = 1; end
                else begin r = s % 16; c = (s > 15) ? 1 : 0; end
            end
            ALU_SUB: begin
                s = a - b - (uc ? cin : 0);
                if (s < 0) begin c = 1; r = (s + (dec ? 10 : 16) + 32) % 16; end
                else begin c = 0; r = s; end
            end
            ALU_CP:  begin s = a - b; c = (s < 0) ? 1 : 0; r = (s + 16) % 16; end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_NOT: r = 15 - a;
            ALU_RRC: begin r = cin * 8 + a / 2; c = a % 2; end
            ALU_RLC: begin r = (a * 2) % 16 + cin; c = a / 8; end
            default: ;
        endcase
    endfunction

    task automatic ram_set(input logic [AW-1:0] addr, input logic [3:0] data);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // issue one instruction (called at a negedge, returns at a negedge in IDLE)
    task automatic run_instr(input alu_op op, input bit uc, input logic [1:0] dst,
                             input logic [2:0] src, input logic [3:0] imm, input bit hammer);
        bus.op = op; bus.op_use_carry = uc; bus.dst_sel = dst; bus.src_sel = src; bus.imm = imm;
        bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hammer) bus.start = 1'b0;
        obs_lat = 0; obs_rd_cnt = 0; obs_wr_cnt = 0; obs_wr_kind = 0; obs_conflict = 0;
        obs_busy_gap = 0; obs_timeout = 1'b1; obs_wr_addr = '0; obs_wr_data = 4'h0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (!bus.busy) obs_busy_gap++;
            if (bus.mem_rd && bus.mem_wr) obs_conflict++;
            if (int'(bus.reg_we_a) + int'(bus.reg_we_b) + int'(bus.mem_wr) > 1) obs_conflict++;
            if (bus.mem_rd) begin
                if (obs_rd_cnt < 4) obs_rd_addr[obs_rd_cnt] = bus.mem_addr;
                obs_rd_cnt++;
            end
            if (bus.reg_we_a) begin obs_wr_cnt++; obs_wr_kind = 1; obs_wr_data = bus.reg_wdata; end
            if (bus.reg_we_b) begin obs_wr_cnt++; obs_wr_kind = 2; obs_wr_data = bus.reg_wdata; end
            if (bus.mem_wr) begin
                obs_wr_cnt++; obs_wr_kind = 3; obs_wr_data = bus.mem_wdata; obs_wr_addr = bus.mem_addr;
            end
            if (bus.done) begin
                obs_lat = n; obs_timeout = 1'b0; bus.start = 1'b0;
                break;
            end
            if (hammer) begin
                bus.op = alu_op'(4'($urandom_range(0, 8)));
                bus.dst_sel = 2'($urandom); bus.src_sel = 3'($urandom); bus.imm = 4'($urandom);
            end
        end
        bus.start = 1'b0;
        if (obs_wr_kind == 1) bus.reg_a = obs_wr_data;
        if (obs_wr_kind == 2) bus.reg_b = obs_wr_data;
        @(negedge clk);
        obs_busy_after = bus.busy;
        obs_done_after = bus.done;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if ({bus.busy, bus.done, bus.reg_we_a, bus.reg_we_b, bus.mem_rd, bus.mem_wr} !== 6'b0)
            $display("FAIL reset_strobes: got %b expected 000000", {bus.busy, bus.done, bus.reg_we_a, bus.reg_we_b, bus.mem_rd, bus.mem_wr}); else passed++;
        checks++; if (bus.mem_addr !== '0) $display("FAIL reset_mem_addr: got %0h expected 0", bus.mem_addr); else passed++;
        checks++; if ({bus.reg_wdata, bus.mem_wdata} !== 8'h00)
            $display("FAIL reset_wdata: got %0h expected 0", {bus.reg_wdata, bus.mem_wdata}); else passed++;
        checks++; if ({bus.flag_carry, bus.flag_zero} !== 2'b00)
            $display("FAIL reset_flags: got %b expected 00", {bus.flag_carry, bus.flag_zero}); else passed++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_directed();
        // binary ADD register/register
        bus.reg_a = 4'h7; bus.reg_b = 4'h5; bus.flag_decimal = 1'b0;
        run_instr(ALU_ADD, 1'b0, 2'd0, 3'd1, 4'h0, 1'b0);
        checks++; if (obs_lat !== 4) $display("FAIL add_latency: got %0d expected 4", obs_lat); else passed++;
        checks++; if (obs_wr_kind !== 1 || obs_wr_data !== 4'hC)
            $display("FAIL add_write: got kind %0d data %0h expected kind 1 data c", obs_wr_kind, obs_wr_data); else passed++;
        checks++; if ({bus.flag_carry, bus.flag_zero} !== 2'b00)
            $display("FAIL add_flags: got %b expected 00", {bus.flag_carry, bus.flag_zero}); else passed++;
        $display("directed ADD A,B lat=%0d wdata=%0h", obs_lat, obs_wr_data);

        // decimal ADD with immediate
        bus.reg_a = 4'h7; bus.flag_decimal = 1'b1;
        run_instr(ALU_ADD, 1'b0, 2'd0, 3'd4, 4'h5, 1'b0);
        checks++; if (obs_wr_data !== 4'h2) $display("FAIL dadd_result: got %0h expected 2", obs_wr_data); else passed++;
        checks++; if ({bus.flag_carry, bus.flag_zero} !== 2'b10)
            $display("FAIL dadd_flags: got %b expected 10", {bus.flag_carry, bus.flag_zero}); else passed++;
        $display("directed decimal ADD A,#5 wdata=%0h", obs_wr_data);

        // SUB RAM/RAM
        bus.flag_decimal = 1'b0; bus.reg_x = 12'h010; bus.reg_y = 12'h020;
        ram_set(12'h010, 4'h3); ram_set(12'h020, 4'h3);
        run_instr(ALU_SUB, 1'b0, 2'd2, 3'd3, 4'h0, 1'b0);
        checks++; if (obs_rd_cnt !== 2 || obs_rd_addr[0] !== 12'h010 || obs_rd_addr[1] !== 12'h020)
            $display("FAIL sub_reads: got %0d reads %0h,%0h expected 2 reads 010,020", obs_rd_cnt, obs_rd_addr[0], obs_rd_addr[1]); else passed++;
        checks++; if (obs_lat !== 6) $display("FAIL sub_latency: got %0d expected 6", obs_lat); else passed++;
        checks++; if (obs_wr_kind !== 3 || obs_wr_addr !== 12'h010 || obs_wr_data !== 4'h0)
            $display("FAIL sub_write: got kind %0d addr %0h data %0h expected 3 010 0", obs_wr_kind, obs_wr_addr, obs_wr_data); else passed++;
        checks++; if ({bus.flag_carry, bus.flag_zero} !== 2'b01)
            $display("FAIL sub_flags: got %b expected 01", {bus.flag_carry, bus.flag_zero}); else passed++;
        $display("directed SUB M(X),M(Y) lat=%0d wdata=%0h", obs_lat, obs_wr_data);

        // CP writes nothing
        bus.reg_a = 4'h2;
        run_instr(ALU_CP, 1'b0, 2'd0, 3'd4, 4'h5, 1'b0);
        checks++; if (obs_wr_cnt !== 0) $display("FAIL cp_no_write: got %0d writes expected 0", obs_wr_cnt); else passed++;
        checks++; if ({bus.flag_carry, bus.flag_zero} !== 2'b10)
            $display("FAIL cp_flags: got %b expected 10", {bus.flag_carry, bus.flag_zero}); else passed++;
        $display("directed CP A,#5 writes=%0d", obs_wr_cnt);
        model_c = 1;
    endtask

    task automatic test_same_cell();
        bus.flag_decimal = 1'b0; bus.reg_x = 12'h030; bus.reg_y = 12'h030;
        ram_set(12'h030, 4'h6);
        run_instr(ALU_ADD, 1'b0, 2'd2, 3'd3, 4'h0, 1'b0);
        checks++; if (obs_rd_cnt !== 2 || obs_rd_addr[0] !== 12'h030 || obs_rd_addr[1] !== 12'h030)
            $display("FAIL same_cell_reads: got %0d reads %0h,%0h expected 2 reads 030,030", obs_rd_cnt, obs_rd_addr[0], obs_rd_addr[1]); else passed++;
        checks++; if (obs_wr_cnt !== 1 || obs_wr_data !== 4'hC || ram[12'h030] !== 4'hC)
            $display("FAIL same_cell_write: got %0d writes data %0h ram %0h expected 1 c c", obs_wr_cnt, obs_wr_data, ram[12'h030]); else passed++;
        model_c = 0;
        $display("same cell ADD M(X),M(X) reads=%0d wdata=%0h", obs_rd_cnt, obs_wr_data);
    endtask

    task automatic test_busy_ignore();
        int extra_done = 0;
        int extra_busy = 0;
        bus.reg_a = 4'h3; bus.reg_b = 4'h4; bus.flag_decimal = 1'b0;
        run_instr(ALU_ADD, 1'b0, 2'd0, 3'd1, 4'h0, 1'b1);
        checks++; if (obs_lat !== 4 || obs_wr_data !== 4'h7 || obs_wr_kind !== 1)
            $display("FAIL busy_start_result: got lat %0d data %0h kind %0d expected 4 7 1", obs_lat, obs_wr_data, obs_wr_kind); else passed++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
            if (bus.busy) extra_busy++;
        end
        checks++; if (extra_done + int'(obs_done_after) !== 0 || extra_busy !== 0)
            $display("FAIL busy_start_single_done: got extra done %0d busy %0d expected 0 0", extra_done, extra_busy); else passed++;
        model_c = 0;
        $display("start held while busy: lat=%0d extra_done=%0d", obs_lat, extra_done);
    endtask

    task automatic test_back_to_back(input int n_iter);
        for (int it = 0; it < n_iter; it++) begin
            alu_op         op;
            bit            uc, dec, unary;
            logic [1:0]    dst;
            logic [2:0]    src;
            logic [3:0]    imm;
            logic [AW-1:0] x, y, eaddr;
            int            a, b, r, c, elat, erd;
            logic [AW-1:0] erd_addr [2];
            op = alu_op'(4'($urandom_range(0, 8)));
            uc = 1'($urandom); dec = 1'($urandom);
            dst = 2'($urandom); src = 3'($urandom); imm = 4'($urandom);
            x = AW'($urandom_range(0, 63));
            y = ($urandom_range(0, 3) == 0) ? x : AW'($urandom_range(0, 63));
            bus.reg_x = x; bus.reg_y = y; bus.flag_decimal = dec;
            bus.reg_a = 4'($urandom); bus.reg_b = 4'($urandom);
            unary = (op == ALU_NOT) || (op == ALU_RRC) || (op == ALU_RLC);
            case (dst)
                2'd0: a = int'(bus.reg_a);
                2'd1: a = int'(bus.reg_b);
                2'd2: a = int'(ram[x]);
                default: a = int'(ram[y]);
            endcase
            case (src)
                3'd0: b = int'(bus.reg_a);
                3'd1: b = int'(bus.reg_b);
                3'd2: b = int'(ram[x]);
                3'd3: b = int'(ram[y]);
                default: b = int'(imm);
            endcase
            if (unary) b = 0;
            ref_alu(op, a, b, model_c, uc, dec, r, c);
            erd = 0;
            if (dst >= 2) begin erd_addr[erd] = (dst == 2) ? x : y; erd++; end
            if (!unary && (src == 3'd2 || src == 3'd3)) begin erd_addr[erd] = (src == 3'd2) ? x : y; erd++; end
            elat = unary ? 3 + erd : 4 + erd;
            eaddr = (dst == 2) ? x : y;
            run_instr(op, uc, dst, src, imm, 1'b0);
            checks++; if (obs_timeout !== 1'b0) $display("FAIL rnd_timeout: iter %0d no done within 20 cycles", it); else passed++;
            checks++; if (obs_lat !== elat) $display("FAIL rnd_latency: iter %0d got %0d expected %0d", it, obs_lat, elat); else passed++;
            checks++; if (obs_rd_cnt !== erd) $display("FAIL rnd_read_count: iter %0d got %0d expected %0d", it, obs_rd_cnt, erd); else passed++;
            for (int k = 0; k < erd; k++) begin
                checks++; if (obs_rd_addr[k] !== erd_addr[k])
                    $display("FAIL rnd_read_addr: iter %0d read %0d got %0h expected %0h", it, k, obs_rd_addr[k], erd_addr[k]); else passed++;
            end
            if (op == ALU_CP) begin
                checks++; if (obs_wr_cnt !== 0) $display("FAIL rnd_cp_write: iter %0d got %0d writes expected 0", it, obs_wr_cnt); else passed++;
            end else begin
                checks++; if (obs_wr_cnt !== 1 || obs_wr_kind !== int'(dst > 1 ? 3 : dst + 1) || obs_wr_data !== 4'(r))
                    $display("FAIL rnd_write: iter %0d got %0d writes kind %0d data %0h expected 1 %0d %0h", it, obs_wr_cnt, obs_wr_kind, obs_wr_data, dst > 1 ? 3 : dst + 1, r); else passed++;
                if (dst >= 2) begin
                    checks++; if (obs_wr_addr !== eaddr) $display("FAIL rnd_write_addr: iter %0d got %0h expected %0h", it, obs_wr_addr, eaddr); else passed++;
                end
            end
            checks++; if (bus.flag_carry !== 1'(c) || bus.flag_zero !== (r == 0))
                $display("FAIL rnd_flags: iter %0d got c=%b z=%b expected c=%0d z=%0d", it, bus.flag_carry, bus.flag_zero, c, r == 0); else passed++;
            checks++; if (obs_conflict !== 0 || obs_busy_gap !== 0 || obs_busy_after !== 1'b0 || obs_done_after !== 1'b0)
                $display("FAIL rnd_protocol: iter %0d conflicts %0d busy_gaps %0d busy_after %b done_after %b expected 0 0 0 0", it, obs_conflict, obs_busy_gap, obs_busy_after, obs_done_after); else passed++;
            model_c = c;
            $display("iter %0d op=%s uc=%0d d=%0d dst=%0d src=%0d a=%0h b=%0h -> r=%0h c=%0d lat=%0d", it, op.name(), uc, dec, dst, src, a, b, r, c, obs_lat);
        end
    endtask

    task automatic test_reset_midflight();
        int bad = 0;
        bit saw_rd_y = 1'b0;
        bus.flag_decimal = 1'b0; bus.reg_x = 12'h040; bus.reg_y = 12'h041;
        ram_set(12'h040, 4'h9); ram_set(12'h041, 4'h4);
        bus.op = ALU_ADD; bus.op_use_carry = 1'b0; bus.dst_sel = 2'd2; bus.src_sel = 3'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 3 && bus.mem_rd && bus.mem_addr == 12'h041) saw_rd_y = 1'b1;
        end
        checks++; if (saw_rd_y !== 1'b1) $display("FAIL midreset_src_read: got %b expected 1", saw_rd_y); else passed++;
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.done, bus.mem_rd, bus.mem_wr, bus.flag_carry, bus.flag_zero} !== 6'b0 || bus.mem_addr !== '0)
            $display("FAIL midreset_outputs: got %b addr %0h expected 000000 0", {bus.busy, bus.done, bus.mem_rd, bus.mem_wr, bus.flag_carry, bus.flag_zero}, bus.mem_addr); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.mem_wr || bus.done) bad++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.mem_wr || bus.done || bus.busy) bad++;
        end
        checks++; if (bad !== 0 || ram[12'h040] !== 4'h9)
            $display("FAIL midreset_no_write: got %0d strobes ram %0h expected 0 9", bad, ram[12'h040]); else passed++;
        model_c = 0;
        bus.reg_a = 4'h8; bus.reg_b = 4'h9;
        run_instr(ALU_ADD, 1'b1, 2'd1, 3'd0, 4'h0, 1'b0);
        checks++; if (obs_lat !== 4 || obs_wr_kind !== 2 || obs_wr_data !== 4'h1 || bus.flag_carry !== 1'b1)
            $display("FAIL midreset_recover: got lat %0d kind %0d data %0h c %b expected 4 2 1 1", obs_lat, obs_wr_kind, obs_wr_data, bus.flag_carry); else passed++;
        model_c = 1;
        $display("mid-instruction reset: strobes=%0d recover wdata=%0h", bad, obs_wr_data);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = ALU_ADD; bus.op_use_carry = 1'b0; bus.dst_sel = 2'd0;
        bus.src_sel = 3'd0; bus.imm = 4'h0; bus.flag_decimal = 1'b0;
        bus.reg_a = 4'h0; bus.reg_b = 4'h0; bus.reg_x = '0; bus.reg_y = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = 4'h0;
        repeat (2) @(negedge clk);
        test_reset();
        for (int i = 0; i < 64; i++) ram_set(AW'(i), 4'($urandom));
        test_directed();
        test_same_cell();
        test_busy_ignore();
        test_back_to_back(150);
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
